// File: rtl/fp_pkg.sv
// Shared float-word constants and converter state encoding, also used by the
// FP adder and multiplier stages.
package fp_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/fxp_to_fp_conv_if.sv
// Valid/ready operand and result channels of the fixed-to-float converter.
interface fxp_to_fp_conv_if
  import fp_pkg::*;
#(
  parameter int IN_W = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [FP_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fp_pack.sv
// Packs sign, unbiased exponent and normalised mantissa into the float word;
// a zero operand always yields +0.
module fp_pack
  import fp_pkg::*;
(
  input  logic                    sign,
  input  logic signed [EXP_W-1:0] exp_val,
  input  logic        [MAN_W-1:0] man,
  input  logic                    zero,
  output logic        [FP_W-1:0]  word
);

  always_comb begin
    word = FP_ZERO;
    if (!zero) begin
      word[SIGN_BIT]        = sign;
      word[EXP_MSB:EXP_LSB] = exp_val;
      word[MAN_W-1:0]       = man;
    end
  end

endmodule

// File: rtl/fxp_to_fp_conv.sv
// Signed fixed-point to float converter: one normalising left shift per cycle,
// mantissa truncated, single operand in flight.
module fxp_to_fp_conv
  import fp_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int FRAC_W = 16
) (
  input logic             clk,
  input logic             rst,
  fxp_to_fp_conv_if.slave bus
);

  localparam logic signed [EXP_W-1:0] EXP_INIT = EXP_W'(IN_W - 1 - FRAC_W);

  conv_state_e              state;
  logic                     sign;
  logic                     zero;
  logic        [IN_W-1:0]   mag;
  logic signed [EXP_W-1:0]  exp_q;
  logic        [IN_W-1:0]   abs_in;
  logic        [FP_W-1:0]   packed_word;

  // The most negative input negates to 2^(IN_W-1), which still fits unsigned.
  assign abs_in = bus.in_data[IN_W-1] ? (~bus.in_data + 1'b1) : bus.in_data;

  // NOTE: in_ready is decoded from state and gated by rst so it is low for the
  // whole reset and high on the very first cycle after release.
  assign bus.in_ready = !rst && (state == IDLE);

  fp_pack u_pack (
    .sign    (sign),
    .exp_val (exp_q),
    .man     (mag[IN_W-1 -: MAN_W]),
    .zero    (zero),
    .word    (packed_word)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sign          <= 1'b0;
      zero          <= 1'b0;
      mag           <= '0;
      exp_q         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= FP_ZERO;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign  <= bus.in_data[IN_W-1];
            mag   <= abs_in;
            exp_q <= EXP_INIT;
            zero  <= (bus.in_data == '0);
            state <= NORM;
          end
        end
        NORM: begin
          if (zero || mag[IN_W-1]) begin
            bus.out_data  <= packed_word;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            mag   <= mag << 1;
            exp_q <= exp_q - 8'sd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_to_fp_conv.sv
// Directed bench for fxp_to_fp_conv (Q16.16 -> float word), plus a short
// model-checked run with random gaps and output stalls.
module tb_fxp_to_fp_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fxp_to_fp_conv_if #(.IN_W(32)) bus ();

  fxp_to_fp_conv #(.IN_W(32), .FRAC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: locate highest set bit, normalise, truncate to 23 mantissa bits.
  function automatic logic [31:0] model(input logic [31:0] d);
    logic [31:0] m;
    logic [31:0] n;
    logic [7:0]  e;
    int          p;
    if (d == 32'h0) return 32'h0;
    m = d[31] ? (32'h0 - d) : d;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    n = m << (31 - p);
    e = 8'(p - 16);
    return {d[31], e, n[31:9]};
  endfunction

  function automatic int model_lat(input logic [31:0] d);
    logic [31:0] m;
    int          p;
    if (d == 32'h0) return 1;
    m = d[31] ? (32'h0 - d) : d;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return 1 + (31 - p);
  endfunction

  // Drives one operand; lat = edges from accept to out_valid (-1 on timeout).
  task automatic convert(input logic [31:0] d, input int gap, input int stall,
                         output logic [31:0] res, output int lat);
    lat = -1;
    res = 32'h0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    res = bus.out_data;
    repeat (stall) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out_data got=%h want=00000000", bus.out_data);
    end
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic run_vectors(input string name, input logic [31:0] din[],
                             input logic [31:0] dout[], input int dlat[]);
    logic [31:0] res;
    int          lat;
    foreach (din[k]) begin
      convert(din[k], 0, 0, res, lat);
      checks++;
      if (res !== dout[k]) begin
        errors++; $display("FAIL %s_data[%0d] in=%h got=%h want=%h", name, k, din[k], res, dout[k]);
      end
      checks++;
      if (lat !== dlat[k]) begin
        errors++; $display("FAIL %s_latency[%0d] in=%h got=%0d want=%0d", name, k, din[k], lat, dlat[k]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] din[]  = '{32'h0009_C000, 32'hFFED_7000, 32'h0001_8000};
    logic [31:0] dout[] = '{32'h01CE_0000, 32'h824A_4000, 32'h0060_0000};
    int          dlat[] = '{13, 12, 16};
    run_vectors("basic", din, dout, dlat);
  endtask

  task automatic test_extremes();
    logic [31:0] din[]  = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] dout[] = '{32'h87C0_0000, 32'h7840_0000, 32'h0000_0000, 32'hF840_0000};
    int          dlat[] = '{1, 32, 1, 32};
    run_vectors("extreme", din, dout, dlat);
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          lat;
    int          waited;
    @(negedge clk);
    bus.in_data  = 32'h0009_C000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 100) begin
      @(posedge clk);
      #1 waited++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_out_valid_timeout got=%b want=1", bus.out_valid);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_data  = 32'h8000_0000;
      bus.in_valid = c[0];
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h01CE_0000 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] valid=%b data=%h ready=%b want valid=1 data=01ce0000 ready=0",
                 c, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    convert(32'h0001_8000, 0, 0, res, lat);
    checks++;
    if (res !== 32'h0060_0000 || lat !== 16) begin
      errors++; $display("FAIL bp_next got=%h lat=%0d want=00600000 lat=16", res, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat;
    logic        seen;
    @(negedge clk);
    bus.in_data  = 32'h0009_C000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_during valid=%b data=%h ready=%b want 0/00000000/0",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready);
    end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (bus.out_valid || bus.out_data !== 32'h0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midrst_abandon got output=%b want=0", seen);
    end
    convert(32'h0001_8000, 0, 0, res, lat);
    checks++;
    if (res !== 32'h0060_0000 || lat !== 16) begin
      errors++; $display("FAIL midrst_next got=%h lat=%0d want=00600000 lat=16", res, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] res;
    int          lat;
    for (int k = 0; k < 24; k++) begin
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = 32'h0 - d;
      convert(d, $urandom_range(0, 3), $urandom_range(0, 4), res, lat);
      checks++;
      if (res !== model(d) || lat !== model_lat(d)) begin
        errors++;
        $display("FAIL random[%0d] in=%h got=%h lat=%0d want=%h lat=%0d",
                 k, d, res, lat, model(d), model_lat(d));
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
